// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Frame layout, MSB first: [rw][addr][data].
package spi_pkg;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   // Frame receive progress
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // chip not selected
      CMD  = 2'd1,   // receiving rw + address
      DATA = 2'd2,   // receiving data field
      DONE = 2'd3    // frame complete, extra bits ignored
   } spi_state_t;

   // Total bits in one frame
   function automatic int frame_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// Chip-side SPI pins of the register-file peripheral (after the pads).
interface spi_regfile_peripheral_if;
   logic SCLK;
   logic nCS;
   logic COPI;
   logic CIPO;
   logic cipo_oe;

   modport master (output SCLK, nCS, COPI, input CIPO, cipo_oe);
   modport slave  (input SCLK, nCS, COPI, output CIPO, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses.
// IDLE_VAL is the level the chain takes on reset, so no spurious edge is
// seen while the pin sits at its idle level.
module spi_sync_edge #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;

   // Shift the pin through the synchroniser chain and keep last level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= {STAGES{IDLE_VAL}};
         prev_reg <= IDLE_VAL;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], async_in};
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign level = sync_reg[STAGES-1];
   assign rise  = sync_reg[STAGES-1] & ~prev_reg;
   assign fall  = ~sync_reg[STAGES-1] & prev_reg;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target exposing NUM_REGS registers of DATA_W bits with write
// and read-back frames. Writes commit one clk after the final bit is seen
// and pulse wr_strobe; the old register value is shifted out on CIPO.
// Optional macro SPI_FRAME_ERR_EN adds err_count, a saturating count of
// aborted and overlong frames.
module spi_regfile_peripheral
   import spi_pkg::*;
#(
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef SPI_FRAME_ERR_EN
   output logic [7:0]                 err_count,
`endif
   spi_regfile_peripheral_if.slave    spi,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr
);
   localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic ncs_level, ncs_rise, ncs_fall;
   logic copi_level, copi_rise_unused, copi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .async_in(spi.SCLK),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .async_in(spi.nCS),
      .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .async_in(spi.COPI),
      .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused));

   spi_state_t         state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [FRAME_W-1:0] shift_in_reg;
   logic [DATA_W-1:0]  shift_out_reg;
   logic               cipo_reg;
   logic               wr_strobe_reg;
   logic [ADDR_W-1:0]  wr_addr_reg;
   logic [DATA_W-1:0]  regs_reg [NUM_REGS];

   logic               bit_rise, bit_fall;
   logic [CNT_W-1:0]   cnt_next;
   logic [FRAME_W-1:0] shift_next;
   logic [ADDR_W-1:0]  rd_addr;
   logic [DATA_W-1:0]  rd_data;
   logic [ADDR_W-1:0]  commit_addr;
   logic [DATA_W-1:0]  commit_data;
   logic               addr_last, frame_done, addr_ok, commit;

   // Edges are gated by the frame state rather than the live nCS level so
   // that a final SCLK rise seen together with the nCS rise still commits.
   assign bit_rise    = sclk_rise & (state_reg != IDLE);
   assign bit_fall    = sclk_fall & (state_reg != IDLE);
   assign cnt_next    = cnt_reg + CNT_W'(1);
   assign shift_next  = {shift_in_reg[FRAME_W-2:0], copi_level};
   assign rd_addr     = shift_next[ADDR_W-1:0];
   assign commit_addr = shift_next[DATA_W +: ADDR_W];
   assign commit_data = shift_next[DATA_W-1:0];
   assign addr_last   = bit_rise && (state_reg == CMD)  && (cnt_next == CNT_W'(1 + ADDR_W));
   assign frame_done  = bit_rise && (state_reg == DATA) && (cnt_next == CNT_W'(FRAME_W));
   assign addr_ok     = {1'b0, commit_addr} < (ADDR_W+1)'(NUM_REGS);
   assign commit      = frame_done && (shift_next[FRAME_W-1] == RW_WRITE) && addr_ok;

   // Read-back mux; unimplemented addresses read as zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_data = regs_reg[i];
      end
   end

   // Frame FSM: bit capture, read-data shifting, commit strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         shift_in_reg  <= '0;
         shift_out_reg <= '0;
         cipo_reg      <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= '0;
      end else begin
         wr_strobe_reg <= commit;
         if (commit) wr_addr_reg <= commit_addr;

         if (bit_rise) begin
            unique case (state_reg)
               CMD: begin
                  shift_in_reg <= shift_next;
                  cnt_reg      <= cnt_next;
                  if (addr_last) begin
                     shift_out_reg <= rd_data;
                     state_reg     <= DATA;
                  end
               end
               DATA: begin
                  shift_in_reg <= shift_next;
                  cnt_reg      <= cnt_next;
                  if (frame_done) state_reg <= DONE;
               end
               default: ;
            endcase
         end

         // Zeros are shifted in, so CIPO idles low outside the data field
         if (bit_fall) begin
            cipo_reg      <= shift_out_reg[DATA_W-1];
            shift_out_reg <= shift_out_reg << 1;
         end

         if (ncs_rise) state_reg <= IDLE;

         if (ncs_fall) begin
            state_reg     <= CMD;
            cnt_reg       <= '0;
            shift_in_reg  <= '0;
            shift_out_reg <= '0;
            cipo_reg      <= 1'b0;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         // Register gi takes the data field of a committed write to it
         always_ff @(posedge clk) begin
            if (rst)
               regs_reg[gi] <= '0;
            else if (commit && (commit_addr == ADDR_W'(gi)))
               regs_reg[gi] <= commit_data;
         end
         assign regs[gi*DATA_W +: DATA_W] = regs_reg[gi];
      end
   endgenerate

`ifdef SPI_FRAME_ERR_EN
   logic       overlong_reg;
   logic [7:0] err_count_reg;
   logic       frame_err;

   assign frame_err = ncs_rise &&
                      ((state_reg == CMD) ||
                       ((state_reg == DATA) && !frame_done) ||
                       ((state_reg == DONE) && (overlong_reg || bit_rise)));

   // Track excess bits and count bad frames, saturating at 255
   always_ff @(posedge clk) begin
      if (rst) begin
         overlong_reg  <= 1'b0;
         err_count_reg <= '0;
      end else begin
         if (ncs_fall)
            overlong_reg <= 1'b0;
         else if (bit_rise && (state_reg == DONE))
            overlong_reg <= 1'b1;
         if (frame_err && (err_count_reg != 8'hFF))
            err_count_reg <= err_count_reg + 8'd1;
      end
   end

   assign err_count = err_count_reg;
`endif

   assign spi.cipo_oe = ~ncs_level;
   assign spi.CIPO    = cipo_reg & ~ncs_level;
   assign wr_strobe   = wr_strobe_reg;
   assign wr_addr     = wr_addr_reg;
endmodule
